// File: rtl/stopwatch_ctrl.sv
// Stopwatch FSM/counter plus timer-vs-stopwatch button steering and display mux; all outputs registered.
// Optional lap hold (LAP state, snapshot, sw_lap) is built only when STOPWATCH_LAP_EN is defined.
module stopwatch_ctrl #(
  parameter int MS_PER_SEC = 1000,
  parameter int MAX_MIN    = 59
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_1k,
  input  logic       mode_sw,
  input  logic       start_btn,
  input  logic       stop_btn,
  input  logic       clr_btn,
  input  logic       lap_btn,
  input  logic       inc_min_btn,
  input  logic       inc_sec_btn,
  input  logic [5:0] tmr_minutes,
  input  logic [5:0] tmr_seconds,
  input  logic       tmr_blink,
  output logic       tmr_start,
  output logic       tmr_stop,
  output logic       tmr_reset,
  output logic       tmr_inc_min,
  output logic       tmr_inc_sec,
  output logic [5:0] minutes,
  output logic [5:0] seconds,
  output logic       blink,
  output logic       sw_running,
  output logic       sw_lap
);

  localparam int MSW = (MS_PER_SEC > 1) ? $clog2(MS_PER_SEC) : 1;
  localparam logic [MSW-1:0] MS_LAST  = MSW'(MS_PER_SEC - 1);
  localparam logic [5:0]     MIN_LAST = 6'(MAX_MIN);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RUN   = 3'd1,
    S_PAUSE = 3'd2,
`ifdef STOPWATCH_LAP_EN
    S_SAT   = 3'd3,
    S_LAP   = 3'd4
`else
    S_SAT   = 3'd3
`endif
  } state_t;

  state_t         r_state, w_state_nxt;
  logic [MSW-1:0] r_ms, w_ms_nxt;
  logic [5:0]     r_sec, w_sec_nxt, r_min, w_min_nxt;
  logic [5:0]     w_sw_min, w_sw_sec;
  logic           w_count, w_lap_act;
  logic           r_start_q, r_start_qq, r_stop_q, r_stop_qq, r_clr_q, r_clr_qq;
  logic           w_start_ev, w_stop_ev, w_clr_ev;
  logic           r_tmr_start, r_tmr_stop, r_tmr_reset, r_tmr_inc_min, r_tmr_inc_sec;
  logic [5:0]     r_minutes, r_seconds;
  logic           r_blink, r_sw_running, r_sw_lap;

  // Events only exist in stopwatch mode; a level held across a mode change has no fresh edge.
  assign w_start_ev = mode_sw & r_start_q & ~r_start_qq;
  assign w_stop_ev  = mode_sw & r_stop_q  & ~r_stop_qq;
  assign w_clr_ev   = mode_sw & r_clr_q   & ~r_clr_qq;

`ifdef STOPWATCH_LAP_EN
  logic       r_lap_q, r_lap_qq, w_lap_ev;
  logic [5:0] r_snap_min, r_snap_sec, w_snap_min_nxt, w_snap_sec_nxt;
  assign w_lap_ev = mode_sw & r_lap_q & ~r_lap_qq;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_lap_q    <= 1'b0;
      r_lap_qq   <= 1'b0;
      r_snap_min <= '0;
      r_snap_sec <= '0;
    end else begin
      r_lap_q    <= lap_btn;
      r_lap_qq   <= r_lap_q;
      r_snap_min <= w_snap_min_nxt;
      r_snap_sec <= w_snap_sec_nxt;
    end
  end
`else
  logic w_unused_lap;
  assign w_unused_lap = lap_btn;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_ms_nxt    = r_ms;
    w_sec_nxt   = r_sec;
    w_min_nxt   = r_min;
    w_count     = 1'b0;
`ifdef STOPWATCH_LAP_EN
    w_snap_min_nxt = r_snap_min;
    w_snap_sec_nxt = r_snap_sec;
`endif
    case (r_state)
      S_IDLE:  if (w_start_ev) w_state_nxt = S_RUN;
      S_RUN: begin
        w_count = ~w_stop_ev;
        if (w_stop_ev) w_state_nxt = S_PAUSE;
`ifdef STOPWATCH_LAP_EN
        else if (!w_start_ev && w_lap_ev) begin
          w_state_nxt    = S_LAP;
          w_snap_min_nxt = r_min;
          w_snap_sec_nxt = r_sec;
        end
`endif
      end
`ifdef STOPWATCH_LAP_EN
      S_LAP: begin
        w_count = ~w_stop_ev;
        if (w_stop_ev) w_state_nxt = S_PAUSE;
        else if (!w_start_ev && w_lap_ev) w_state_nxt = S_RUN;
      end
`endif
      S_PAUSE: if (w_start_ev) w_state_nxt = S_RUN;
      S_SAT:   w_state_nxt = S_SAT;
      default: w_state_nxt = S_IDLE;
    endcase

    // The terminal tick saturates rather than wrapping; counters stay at MAX_MIN:59.
    if (w_count && tick_1k) begin
      if (r_ms != MS_LAST) begin
        w_ms_nxt = r_ms + 1'b1;
      end else if (r_sec != 6'd59) begin
        w_ms_nxt  = '0;
        w_sec_nxt = r_sec + 6'd1;
      end else if (r_min != MIN_LAST) begin
        w_ms_nxt  = '0;
        w_sec_nxt = '0;
        w_min_nxt = r_min + 6'd1;
      end else begin
        w_state_nxt = S_SAT;
      end
    end

    if (w_clr_ev) begin
      w_state_nxt = S_IDLE;
      w_ms_nxt    = '0;
      w_sec_nxt   = '0;
      w_min_nxt   = '0;
`ifdef STOPWATCH_LAP_EN
      w_snap_min_nxt = '0;
      w_snap_sec_nxt = '0;
`endif
    end
  end

  always_comb begin
    w_sw_min  = w_min_nxt;
    w_sw_sec  = w_sec_nxt;
    w_lap_act = 1'b0;
`ifdef STOPWATCH_LAP_EN
    if (w_state_nxt == S_LAP) begin
      w_sw_min  = w_snap_min_nxt;
      w_sw_sec  = w_snap_sec_nxt;
      w_lap_act = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_ms          <= '0;
      r_sec         <= '0;
      r_min         <= '0;
      r_start_q     <= 1'b0;
      r_start_qq    <= 1'b0;
      r_stop_q      <= 1'b0;
      r_stop_qq     <= 1'b0;
      r_clr_q       <= 1'b0;
      r_clr_qq      <= 1'b0;
      r_tmr_start   <= 1'b0;
      r_tmr_stop    <= 1'b0;
      r_tmr_reset   <= 1'b0;
      r_tmr_inc_min <= 1'b0;
      r_tmr_inc_sec <= 1'b0;
      r_minutes     <= '0;
      r_seconds     <= '0;
      r_blink       <= 1'b0;
      r_sw_running  <= 1'b0;
      r_sw_lap      <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_ms          <= w_ms_nxt;
      r_sec         <= w_sec_nxt;
      r_min         <= w_min_nxt;
      r_start_q     <= start_btn;
      r_start_qq    <= r_start_q;
      r_stop_q      <= stop_btn;
      r_stop_qq     <= r_stop_q;
      r_clr_q       <= clr_btn;
      r_clr_qq      <= r_clr_q;
      r_tmr_start   <= ~mode_sw & start_btn;
      r_tmr_stop    <= ~mode_sw & stop_btn;
      r_tmr_reset   <= ~mode_sw & clr_btn;
      r_tmr_inc_min <= ~mode_sw & inc_min_btn;
      r_tmr_inc_sec <= ~mode_sw & inc_sec_btn;
      // Display and status track the next state so they land on the same edge as the FSM.
      r_minutes     <= mode_sw ? w_sw_min : tmr_minutes;
      r_seconds     <= mode_sw ? w_sw_sec : tmr_seconds;
      r_blink       <= mode_sw ? (w_state_nxt == S_SAT) : tmr_blink;
      r_sw_running  <= (w_state_nxt == S_RUN) | w_lap_act;
      r_sw_lap      <= w_lap_act;
    end
  end

  assign tmr_start   = r_tmr_start;
  assign tmr_stop    = r_tmr_stop;
  assign tmr_reset   = r_tmr_reset;
  assign tmr_inc_min = r_tmr_inc_min;
  assign tmr_inc_sec = r_tmr_inc_sec;
  assign minutes     = r_minutes;
  assign seconds     = r_seconds;
  assign blink       = r_blink;
  assign sw_running  = r_sw_running;
  assign sw_lap      = r_sw_lap;

endmodule

// File: doc/stopwatch_ctrl.md
# stopwatch_ctrl

Stopwatch sequencer and display arbiter that sits between the board buttons, the existing countdown timer and the display driver. It runs its own minutes/seconds/millisecond stopwatch counter from a 1 kHz tick. It steers button activity to either the timer or the stopwatch according to a mode switch. It multiplexes the selected source's minutes, seconds and blink onto the single display path.

## Interface
Parameters:
- MS_PER_SEC, 1000, tick_1k pulses per stopwatch second
- MAX_MIN, 59, highest minutes value before saturation

Ports:
- clk  in  1  system clock (25 MHz)
- rst  in  1  synchronous, active-high reset
- tick_1k  in  1  one-clk-wide enable pulse at 1 kHz, synchronous to clk
- mode_sw  in  1  0 = timer mode, 1 = stopwatch mode
- start_btn  in  1  raw start button level
- stop_btn  in  1  raw stop button level
- clr_btn  in  1  raw clear/soft-reset level
- lap_btn  in  1  raw lap button level
- inc_min_btn, inc_sec_btn  in  1 each  raw increment button levels
- tmr_minutes, tmr_seconds  in  6 each  timer counter values
- tmr_blink  in  1  timer blink request
- tmr_start, tmr_stop, tmr_reset, tmr_inc_min, tmr_inc_sec  out  1 each  gated timer controls
- minutes, seconds  out  6 each  values routed to the display driver
- blink  out  1  blink request routed to the blinking display
- sw_running  out  1  stopwatch state is RUN or LAP
- sw_lap  out  1  lap display hold active

## Operation
- **Button edges:** start, stop, clr and lap are registered once. A press is the rising edge of the registered level, giving a one-clk event. No debounce is performed.
- **Timer mode (mode_sw=0):**
  - tmr_* outputs equal the corresponding raw button levels; tmr_reset equals clr_btn.
  - minutes/seconds/blink = tmr_minutes/tmr_seconds/tmr_blink.
  - Stopwatch button events are ignored. The stopwatch keeps counting if it is in RUN or LAP.
- **Stopwatch mode (mode_sw=1):**
  - All tmr_* outputs are forced to 0.
  - Button events drive the FSM.
  - minutes/seconds come from the stopwatch, or from the lap snapshot while in LAP.
- **FSM states:**
  - **IDLE:** counters zero. start → RUN.
  - **RUN:** counting. stop → PAUSE; lap → LAP (snapshot current min/sec); overflow → SAT.
  - **PAUSE:** counters frozen. start → RUN; lap ignored.
  - **LAP:** counting continues while the display shows the snapshot. lap → RUN; stop → PAUSE (snapshot released); overflow → SAT.
  - **SAT:** display 59:59, counting halted, blink=1.
  - **Clear from any state:** clr → IDLE, counters and snapshot cleared.
- **Event priority (same cycle):** clr > stop > start > lap.
- **Counter:**
  - ms 0..MS_PER_SEC-1, advancing on tick_1k in RUN/LAP. At wrap, seconds increments.
  - seconds 0..59; at wrap, minutes increments.
  - A tick at MAX_MIN:59:MS_PER_SEC-1 enters SAT instead of wrapping. Minutes/seconds hold at MAX_MIN:59.
- **blink in stopwatch mode:** 1 only in SAT.

## Timing
- **Reset values:**
  - State IDLE; ms/seconds/minutes/snapshot 0.
  - minutes=0, seconds=0, blink=0, sw_running=0, sw_lap=0.
  - All tmr_* = 0. All outputs are registered.
- **Latency:**
  - Raw button level → FSM state change: 2 clk (edge register + state register).
  - tick_1k → counter output: 1 clk.
  - mode_sw change → mux output: 1 clk.
- **Held buttons:** a button held across a mode_sw change generates no event. Only a new rising edge acts.
- **tick_1k coinciding with stop:** the stop wins and the tick is not counted.
- **tick_1k coinciding with start out of PAUSE:** the tick is not counted; counting begins on the next tick.
- **Reset mid-operation:** rst overrides all state in the same cycle.

## Configuration
- **STOPWATCH_LAP_EN defined:** LAP state, snapshot registers and the sw_lap output are active as described above.
- **STOPWATCH_LAP_EN not defined:**
  - LAP state and snapshot logic are not built, and lap_btn is ignored.
  - sw_lap is tied to 0.
  - The FSM is IDLE/RUN/PAUSE/SAT only.

## Test plan
- **Reset and basic count:** rst, mode_sw=1, start pulse, 61,500 tick_1k → minutes=1, seconds=1, sw_running=1, blink=0.
- **Pause and resume:** stop after 3,000 ticks, then 2,000 ticks, then start and 1,000 ticks → seconds=4.
- **Lap (LAP_EN defined):** lap at 00:05, then 10,000 ticks → display 00:05 and sw_lap=1. Lap again → display 00:15.
- **Saturation:** preload via 3,599,999 ticks, then 1 tick → 59:59, blink=1, counting halted. clr → 00:00, state IDLE.
- **Mode arbitration:** stopwatch RUN, mode_sw=0, press start_btn → tmr_start=1, stopwatch unaffected and still counting, display shows tmr_minutes/tmr_seconds.
- **Simultaneous events:** stop and start rising in the same cycle while in RUN → PAUSE. clr with start → IDLE, 00:00.
